// File: rtl/pb_press_classifier.sv
// Push-button press classifier: turns a rise pulse plus the button level into
// short-press, long-press and auto-repeat pulses. Auto-repeat is built only when PB_AUTO_REPEAT_EN is defined.
module pb_press_classifier #(
  parameter int MIN_CYC    = 3,
  parameter int LONG_CYC   = 20,
  parameter int REPEAT_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic press_rise,
  input  logic press_lvl,
  output logic short_press,
  output logic long_press,
  output logic rpt_pulse,
  output logic held
);

  localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] MIN_VAL   = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef PB_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             short_nxt_s;
  logic             long_nxt_s;
  logic             rpt_nxt_s;

  // Next-state, counter and output-pulse decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    short_nxt_s = 1'b0;
    long_nxt_s  = 1'b0;
    rpt_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_rise) begin
          state_nxt_s = PRESSED;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESSED: begin
        if (!press_lvl) begin
          // Release: only presses at least MIN_CYC long count; shorter ones are glitches.
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          short_nxt_s = (cnt_r >= MIN_VAL);
        end else if (cnt_r == LONG_LAST) begin
          state_nxt_s = HELD;
          cnt_nxt_s   = '0;
          long_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + 1'b1;
        end
      end
      HELD: begin
        if (!press_lvl) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
`ifdef PB_AUTO_REPEAT_EN
          if (cnt_r == RPT_LAST) begin
            cnt_nxt_s = '0;
            rpt_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + 1'b1;
          end
`else
          cnt_nxt_s = '0;
`endif
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt_pulse   <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      short_press <= short_nxt_s;
      long_press  <= long_nxt_s;
      rpt_pulse   <= rpt_nxt_s;
      held        <= (state_nxt_s == HELD);
    end
  end

endmodule

// File: tb/tb_pb_press_classifier.sv
// Directed bench for pb_press_classifier with default parameters; expected pulse
// cycles are hand-computed per scenario (rise always at scenario cycle 0).
module tb_pb_press_classifier;

  logic clk;
  logic rst;
  logic press_rise;
  logic press_lvl;
  logic short_press;
  logic long_press;
  logic rpt_pulse;
  logic held;

  int checks = 0;
  int errors = 0;

  pb_press_classifier #(.MIN_CYC(3), .LONG_CYC(20), .REPEAT_CYC(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .press_rise (press_rise),
    .press_lvl  (press_lvl),
    .short_press(short_press),
    .long_press (long_press),
    .rpt_pulse  (rpt_pulse),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One scenario: rise at cycle 0, level high through lvl_last; -1 disables an item.
  task automatic run_scn(input string name, input int ncyc, input int lvl_last,
                         input int xrise, input int rst_a, input int rst_d, input int rise2,
                         input int exp_short, input int exp_long,
                         input int held_first, input int held_last,
                         input int rpt_first, input int rpt_last);
    logic e_rpt;
    for (int c = 0; c < ncyc; c++) begin
      press_rise = (c == 0) || (c == xrise) || (c == rise2);
      press_lvl  = (c <= lvl_last);
      rst        = (rst_a >= 0) && (c >= rst_a) && (c <= rst_d);
      #1;
      e_rpt = (rpt_first >= 0) && (c >= rpt_first) && (c <= rpt_last) &&
              (((c - rpt_first) % 5) == 0);
      check($sformatf("%s.short@%0d", name, c), short_press, c == exp_short);
      check($sformatf("%s.long@%0d", name, c), long_press, c == exp_long);
      check($sformatf("%s.rpt@%0d", name, c), rpt_pulse, e_rpt);
      check($sformatf("%s.held@%0d", name, c), held,
            (held_first >= 0) && (c >= held_first) && (c <= held_last));
      @(posedge clk);
      #1;
    end
    press_rise = 1'b0;
    press_lvl  = 1'b0;
    rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    press_rise = 1'b0;
    press_lvl  = 1'b0;
    #12;
    check("reset.short", short_press, 1'b0);
    check("reset.long", long_press, 1'b0);
    check("reset.rpt", rpt_pulse, 1'b0);
    check("reset.held", held, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Short press: low from 6 -> short in 7.
    run_scn("short", 10, 5, -1, -1, -1, -1, 7, -1, -1, -1, -1, -1);
    // Glitch: low from 2 -> nothing.
    run_scn("glitch", 6, 1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    // Boundary: low from 4 gives cnt==MIN -> short in 5.
    run_scn("min_ok", 8, 3, -1, -1, -1, -1, 5, -1, -1, -1, -1, -1);
    // Boundary: low from 3 gives cnt==MIN-1 -> rejected.
    run_scn("min_rej", 8, 2, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    // Release in the cycle with cnt==LONG-1: still a short press in 21.
    run_scn("long_edge", 24, 19, -1, -1, -1, -1, 21, -1, -1, -1, -1, -1);
`ifdef PB_AUTO_REPEAT_EN
    run_scn("long_rpt", 42, 38, -1, -1, -1, -1, -1, 21, 21, 39, 26, 36);
`else
    run_scn("long_norpt", 42, 38, -1, -1, -1, -1, -1, 21, 21, 39, -1, -1);
`endif
    // Extra rise in cycle 4 must be ignored.
    run_scn("xrise", 10, 5, 4, -1, -1, -1, 7, -1, -1, -1, -1, -1);
    // Reset mid-press, level kept high; fresh rise at 15 -> long in 36.
    run_scn("rst_mid", 40, 39, -1, 10, 11, 15, -1, 36, 36, 39, -1, -1);
    // After the HELD release above, a plain short press must still classify.
    run_scn("after", 10, 5, -1, -1, -1, -1, 7, -1, -1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
